mul_sequencer: RTL and testbench

Multi-cycle radix-2 shift-add multiplier with its control FSM, executing RV32M MUL, MULH, MULHSU and MULHU for the multicycle core. It sits behind the multiplier decoder. It accepts a decoded `MULop`, two register operands and a start request, iterates over 32 cycles, and returns the selected 32-bit half of the 64-bit product with a one-cycle ready pulse. Zero operands take an early-out path.

---
 rtl/mul_sequencer.sv | 83 ++++++++
 tb/tb_mul_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
module mul_sequencer #(
  parameter bit EARLY_OUT    = 1'b1,
  parameter int MUL_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mul_valid,
  input  logic [MUL_OP_WIDTH-1:0] MULop,
  input  logic [31:0]             rs1,
  input  logic [31:0]             rs2,
  output logic [31:0]             rd,
  output logic                    mul_ready,
  output logic                    busy
);
  localparam logic [MUL_OP_WIDTH-1:0] OP_MUL    = MUL_OP_WIDTH'(0);
  localparam logic [MUL_OP_WIDTH-1:0] OP_MULH   = MUL_OP_WIDTH'(1);
  localparam logic [MUL_OP_WIDTH-1:0] OP_MULHSU = MUL_OP_WIDTH'(2);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [MUL_OP_WIDTH-1:0] op;
  logic [31:0] r1, r2, a, b;
  logic [63:0] acc, prod;
  logic [32:0] sum;
  logic [4:0]  cnt;
  logic        neg, s1, s2, zero;
  assign s1   = (op == OP_MULH || op == OP_MULHSU) && r1[31];
  assign s2   = (op == OP_MULH) && r2[31];
  assign zero = EARLY_OUT && (r1 == 32'd0 || r2 == 32'd0);
  // 33-bit sum keeps the carry that is shifted back into acc[63]
  assign sum  = {1'b0, acc[63:32]} + {1'b0, b[0] ? a : 32'd0};
  assign prod = neg ? -acc : acc;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    mul_ready = state == DONE;
    busy      = state != IDLE;
    case (state)
      IDLE:    state_nx = mul_valid ? PREP : IDLE;
      PREP:    state_nx = zero ? DONE : CALC;
      CALC:    state_nx = cnt == 5'd31 ? FIX : CALC;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      op  <= '0;
      r1  <= '0;
      r2  <= '0;
      a   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      rd  <= '0;
    end else begin
      case (state)
        IDLE: if (mul_valid) begin
          op <= MULop;
          r1 <= rs1;
          r2 <= rs2;
        end
        PREP: begin
          a   <= s1 ? -r1 : r1;
          b   <= s2 ? -r2 : r2;
          neg <= s1 ^ s2;
          acc <= '0;
          cnt <= '0;
          if (zero) rd <= '0;
        end
        CALC: begin
          acc <= {sum, acc[31:1]};
          b   <= b >> 1;
          cnt <= cnt + 5'd1;
        end
        FIX: rd <= op == OP_MUL ? prod[31:0] : prod[63:32];
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of the shift-add multiplier sequencer.
module tb_mul_sequencer;
  logic clk = 1'b0, resetn = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [1:0]  MULop = 2'd0;
  logic [31:0] rs1 = '0, rs2 = '0, rd0, rd1;
  logic rdy0, rdy1, busy0, busy1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.EARLY_OUT(1'b0)) u_full (.clk(clk), .resetn(resetn), .mul_valid(v0), .MULop(MULop),
    .rs1(rs1), .rs2(rs2), .rd(rd0), .mul_ready(rdy0), .busy(busy0));
  mul_sequencer u_dut (.clk(clk), .resetn(resetn), .mul_valid(v1), .MULop(MULop),
    .rs1(rs1), .rs2(rs2), .rd(rd1), .mul_ready(rdy1), .busy(busy1));

  // Starts one op on the selected instance; lat = cycle k (t0+k) in which mul_ready is seen, 0 on timeout
  task automatic run_op(input bit w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit tog, output int lat, output logic [31:0] r, output logic bsy);
    @(negedge clk);
    MULop = op; rs1 = a; rs2 = b;
    if (w) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    lat = 0; r = 'x; bsy = 1'bx;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bsy = w ? busy1 : busy0;
      if (w ? rdy1 : rdy0) begin
        lat = k;
        r = w ? rd1 : rd0;
      end
      v0 = 1'b0;
      v1 = tog && k < 30 ? k[0] : 1'b0;
      if (tog) begin
        rs1 = $urandom;
        MULop = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_reset;
    #2;
    if (rd1 !== 32'd0) begin n_bad++; $display("FAIL reset_rd got %h want 0", rd1); end
    n_cmp++;
    if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", rdy1); end
    n_cmp++;
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
    n_cmp++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] r; logic bsy;
    run_op(1'b1, 2'd0, 32'd7, 32'd6, 1'b0, lat, r, bsy);
    if (lat !== 35) begin n_bad++; $display("FAIL mul_lat got %0d want 35", lat); end
    n_cmp++;
    if (r !== 32'h2A) begin n_bad++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
    n_cmp++;
    if (bsy !== 1'b1) begin n_bad++; $display("FAIL busy_prep got %b want 1", bsy); end
    n_cmp++;
    @(negedge clk);
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got %b want 0", busy1); end
    n_cmp++;
    if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL ready_pulse got %b want 0", rdy1); end
    n_cmp++;
    if (rd1 !== 32'h2A) begin n_bad++; $display("FAIL rd_hold got %h want 0000002a", rd1); end
    n_cmp++;
    run_op(1'b1, 2'd0, 32'hFFFFFFFD, 32'd5, 1'b0, lat, r, bsy);
    if (r !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL mul_neg got %h want fffffff1", r); end
    n_cmp++;
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] r; logic bsy;
    run_op(1'b1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, r, bsy);
    if (r !== 32'h0) begin n_bad++; $display("FAIL mulh_m1 got %h want 00000000", r); end
    n_cmp++;
    run_op(1'b1, 2'd1, 32'h80000000, 32'h80000000, 1'b0, lat, r, bsy);
    if (r !== 32'h40000000) begin n_bad++; $display("FAIL mulh_min got %h want 40000000", r); end
    n_cmp++;
    run_op(1'b1, 2'd1, 32'hFFFFFFFE, 32'd3, 1'b0, lat, r, bsy);
    if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mulh_mixed got %h want ffffffff", r); end
    n_cmp++;
  endtask

  task automatic test_mulhsu_mulhu;
    int lat; logic [31:0] r; logic bsy;
    run_op(1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, r, bsy);
    if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mulhsu got %h want ffffffff", r); end
    n_cmp++;
    run_op(1'b1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, r, bsy);
    if (r !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mulhu got %h want fffffffe", r); end
    n_cmp++;
  endtask

  task automatic test_early_out;
    int lat; logic [31:0] r; logic bsy;
    run_op(1'b1, 2'd3, 32'd0, 32'h12345678, 1'b0, lat, r, bsy);
    if (lat !== 2) begin n_bad++; $display("FAIL early_lat got %0d want 2", lat); end
    n_cmp++;
    if (r !== 32'd0) begin n_bad++; $display("FAIL early_rd got %h want 0", r); end
    n_cmp++;
    run_op(1'b0, 2'd0, 32'd5, 32'd9, 1'b0, lat, r, bsy);
    if (r !== 32'd45) begin n_bad++; $display("FAIL full_mul got %h want 0000002d", r); end
    n_cmp++;
    run_op(1'b0, 2'd3, 32'd0, 32'h12345678, 1'b0, lat, r, bsy);
    if (lat !== 35) begin n_bad++; $display("FAIL noearly_lat got %0d want 35", lat); end
    n_cmp++;
    if (r !== 32'd0) begin n_bad++; $display("FAIL noearly_rd got %h want 0", r); end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    int lat1 = 0, lat2 = 0; logic [31:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    MULop = 2'd0; rs1 = 32'd7; rs2 = 32'd6; v1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60 && lat1 == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin rs1 = 32'd3; rs2 = 32'd4; end
      if (rdy1) begin lat1 = k; r1 = rd1; end
    end
    if (r1 !== 32'd42) begin n_bad++; $display("FAIL b2b_first got %h want 0000002a", r1); end
    n_cmp++;
    for (int k = 1; k <= 60 && lat2 == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_ready got %b want 0", rdy1); end
        n_cmp++;
      end
      if (k == 2) v1 = 1'b0;
      if (rdy1) begin lat2 = k; r2 = rd1; end
    end
    v1 = 1'b0;
    if (lat2 !== 36) begin n_bad++; $display("FAIL b2b_spacing got %0d want 36", lat2); end
    n_cmp++;
    if (r2 !== 32'd12) begin n_bad++; $display("FAIL b2b_second got %h want 0000000c", r2); end
    n_cmp++;
  endtask

  task automatic test_toggle;
    int lat; logic [31:0] r; logic bsy;
    run_op(1'b1, 2'd0, 32'h00012345, 32'h10, 1'b1, lat, r, bsy);
    if (lat !== 35) begin n_bad++; $display("FAIL toggle_lat got %0d want 35", lat); end
    n_cmp++;
    if (r !== 32'h00123450) begin n_bad++; $display("FAIL toggle_rd got %h want 00123450", r); end
    n_cmp++;
  endtask

  task automatic test_reset_mid;
    int lat, pulses = 0; logic [31:0] r; logic bsy;
    @(negedge clk);
    MULop = 2'd0; rs1 = 32'd9; rs2 = 32'd9; v1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    if (rd1 !== 32'd0) begin n_bad++; $display("FAIL rst_mid_rd got %h want 0", rd1); end
    n_cmp++;
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b want 0", busy1); end
    n_cmp++;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy1) pulses++;
    end
    if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_pulse got %0d want 0", pulses); end
    n_cmp++;
    run_op(1'b1, 2'd0, 32'd2, 32'd2, 1'b0, lat, r, bsy);
    if (lat !== 35) begin n_bad++; $display("FAIL rst_after_lat got %0d want 35", lat); end
    n_cmp++;
    if (r !== 32'd4) begin n_bad++; $display("FAIL rst_after_rd got %h want 4", r); end
    n_cmp++;
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh;
    test_mulhsu_mulhu;
    test_early_out;
    test_back_to_back;
    test_toggle;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
